// File: rtl/io_tape_dev_if.sv
// Host-side FIFO ports and I/O-unit handshakes of the tape reader/punch endpoint.
// slave = the device, master = the host bridge plus I/O unit driving it.
interface io_tape_dev_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clear_from_pnl;
  logic          tape_wr_valid;
  logic          tape_wr_ready;
  logic [4:0]    tape_wr_data;
  logic          punch_rd_valid;
  logic          punch_rd_ready;
  logic [4:0]    punch_rd_data;
  logic          punch_end_pulse;
  logic [LW-1:0] reader_level;
  logic [LW-1:0] punch_level;
  logic          input_rdy_to_io;
  logic          input_ack_from_io;
  logic [4:0]    input_data_to_io;
  logic          output_rdy_from_io;
  logic          output_ack_to_io;
  logic [4:0]    output_data_from_io;

  modport slave (
    input  clear_from_pnl, tape_wr_valid, tape_wr_data, punch_rd_ready,
           input_ack_from_io, output_rdy_from_io, output_data_from_io,
    output tape_wr_ready, punch_rd_valid, punch_rd_data, punch_end_pulse,
           reader_level, punch_level, input_rdy_to_io, input_data_to_io,
           output_ack_to_io
  );

  modport master (
    output clear_from_pnl, tape_wr_valid, tape_wr_data, punch_rd_ready,
           input_ack_from_io, output_rdy_from_io, output_data_from_io,
    input  tape_wr_ready, punch_rd_valid, punch_rd_data, punch_end_pulse,
           reader_level, punch_level, input_rdy_to_io, input_data_to_io,
           output_ack_to_io
  );
endinterface

// File: rtl/io_tape_dev.sv
// Tape reader/punch endpoint: host FIFOs bridged to the I/O unit's 4-phase rdy/ack handshakes.
// Reader rdy rises one edge after a pop; punch ack withheld while its FIFO is full.
module io_tape_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [W-1:0]           i_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dat,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];
  // Clear beats any same-cycle push or pop.
  assign w_push  = i_push && !o_full && resetn && !i_clr;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (!resetn || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module io_tape_dev #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          resetn,
  io_tape_dev_if.slave  io
);
  localparam int         LW          = $clog2(DEPTH) + 1;
  localparam int         CW          = $clog2(GAP_CYCLES + 2);
  localparam logic [4:0] FINISH_CODE = 5'b00110;

  typedef enum logic [1:0] {R_IDLE, R_RDY, R_ACKLOW, R_GAP} rd_state_t;
  typedef enum logic       {P_IDLE, P_ACK} pn_state_t;

  rd_state_t     r_rd_state;
  pn_state_t     r_pn_state;
  logic [4:0]    r_data;
  logic [CW-1:0] r_gap_cnt;
  logic          r_in_rdy;
  logic          r_out_ack;
  logic          r_end_pulse;

  logic          w_host_wr;
  logic          w_rd_pop;
  logic          w_rd_empty;
  logic          w_rd_full;
  logic [4:0]    w_rd_head;
  logic [LW-1:0] w_rd_level;
  logic          w_pn_push;
  logic          w_pn_pop;
  logic          w_pn_empty;
  logic          w_pn_full;
  logic [4:0]    w_pn_head;
  logic [LW-1:0] w_pn_level;

  assign io.tape_wr_ready = !w_rd_full && resetn;
  assign w_host_wr        = io.tape_wr_valid && io.tape_wr_ready;
  assign w_rd_pop         = (r_rd_state == R_IDLE) && !w_rd_empty && !io.clear_from_pnl;
  assign w_pn_push        = (r_pn_state == P_IDLE) && io.output_rdy_from_io && !w_pn_full;
  assign w_pn_pop         = io.punch_rd_valid && io.punch_rd_ready;

  io_tape_fifo #(.DEPTH(DEPTH), .W(5)) u_reader_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (io.clear_from_pnl),
    .i_push  (w_host_wr),
    .i_dat   (io.tape_wr_data),
    .i_pop   (w_rd_pop),
    .o_dat   (w_rd_head),
    .o_empty (w_rd_empty),
    .o_full  (w_rd_full),
    .o_level (w_rd_level)
  );

  io_tape_fifo #(.DEPTH(DEPTH), .W(5)) u_punch_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (io.clear_from_pnl),
    .i_push  (w_pn_push),
    .i_dat   (io.output_data_from_io),
    .i_pop   (w_pn_pop),
    .o_dat   (w_pn_head),
    .o_empty (w_pn_empty),
    .o_full  (w_pn_full),
    .o_level (w_pn_level)
  );

  // Clear empties the FIFOs only; a reader handshake in flight runs to completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_in_rdy   <= 1'b0;
      r_data     <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (w_rd_pop) begin
          r_data     <= w_rd_head;
          r_rd_state <= R_RDY;
          r_in_rdy   <= 1'b1;
        end
        R_RDY: if (io.input_ack_from_io) begin
          r_rd_state <= R_ACKLOW;
          r_in_rdy   <= 1'b0;
        end
        R_ACKLOW: if (!io.input_ack_from_io) begin
          if (GAP_CYCLES == 0) begin
            r_rd_state <= R_IDLE;
          end else begin
            r_rd_state <= R_GAP;
            r_gap_cnt  <= CW'(GAP_CYCLES);
          end
        end
        R_GAP: begin
          if (r_gap_cnt <= CW'(1)) r_rd_state <= R_IDLE;
          else                     r_gap_cnt  <= r_gap_cnt - CW'(1);
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // A push discarded by a coincident clear still completes its handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pn_state  <= P_IDLE;
      r_out_ack   <= 1'b0;
      r_end_pulse <= 1'b0;
    end else begin
      r_end_pulse <= w_pn_push && !io.clear_from_pnl &&
                     (io.output_data_from_io == FINISH_CODE);
      case (r_pn_state)
        P_IDLE: if (w_pn_push) begin
          r_pn_state <= P_ACK;
          r_out_ack  <= 1'b1;
        end
        P_ACK: if (!io.output_rdy_from_io) begin
          r_pn_state <= P_IDLE;
          r_out_ack  <= 1'b0;
        end
        default: r_pn_state <= P_IDLE;
      endcase
    end
  end

  assign io.input_rdy_to_io  = r_in_rdy;
  assign io.input_data_to_io = r_data;
  assign io.output_ack_to_io = r_out_ack;
  assign io.punch_end_pulse  = r_end_pulse;
  assign io.punch_rd_valid   = !w_pn_empty;
  assign io.punch_rd_data    = w_pn_head;
  assign io.reader_level     = w_rd_level;
  assign io.punch_level      = w_pn_level;
endmodule

// File: tb/tb_io_tape_dev.sv
// Bench for io_tape_dev: directed sequences, a punch vector table and a randomized queue-model run.
module tb_io_tape_dev;
  localparam int DEPTH = 16;
  localparam int GAP   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  io_tape_dev_if #(.DEPTH(DEPTH)) bus();
  io_tape_dev #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic auto_ack  = 1'b0;
  logic man_ack   = 1'b0;
  logic model_ack = 1'b0;
  logic [4:0] rd_got[$];
  int rise_cyc[$];
  int fall_cyc[$];

  assign bus.input_ack_from_io = auto_ack ? model_ack : man_ack;

  always @(posedge clk) cyc <= cyc + 1;

  // I/O unit reader side: ack follows rdy one cycle later, logs each delivered code.
  always @(negedge clk) begin
    if (auto_ack && bus.input_rdy_to_io && !model_ack) begin
      rd_got.push_back(bus.input_data_to_io);
      rise_cyc.push_back(cyc);
    end
    if (auto_ack && !bus.input_rdy_to_io && model_ack) fall_cyc.push_back(cyc);
    model_ack = auto_ack && bus.input_rdy_to_io;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [4:0] code);
    int t = 0;
    while (!bus.tape_wr_ready && t < 500) begin
      step();
      t++;
    end
    check("wr_ready_wait", bus.tape_wr_ready, 1);
    bus.tape_wr_valid = 1'b1;
    bus.tape_wr_data  = code;
    step();
    bus.tape_wr_valid = 1'b0;
  endtask

  task automatic punch_send(input logic [4:0] code, output logic endp, output logic endp_next);
    int t = 0;
    bus.output_data_from_io = code;
    bus.output_rdy_from_io  = 1'b1;
    while (!bus.output_ack_to_io && t < 100) begin
      step();
      t++;
    end
    check("pn_ack_rise", bus.output_ack_to_io, 1);
    endp = bus.punch_end_pulse;
    bus.output_rdy_from_io = 1'b0;
    step();
    endp_next = bus.punch_end_pulse;
    check("pn_ack_fall", bus.output_ack_to_io, 0);
  endtask

  task automatic drain_one(output logic [4:0] d);
    d = bus.punch_rd_data;
    bus.punch_rd_ready = 1'b1;
    step();
    bus.punch_rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [4:0]    code;
    logic          endp;
    logic [LW-1:0] lvl;
  } pvec_t;

  initial begin
    pvec_t      pv[5];
    logic [4:0] burst_exp[17];
    logic [4:0] bp_exp[16];
    logic [4:0] d;
    logic       e0, e1;
    logic [4:0] exp_rd[$];
    logic [4:0] exp_pn[$];
    logic [4:0] got_pn[$];
    int         t, nrdy;

    pv[0] = '{5'b11110, 1'b0, LW'(1)};
    pv[1] = '{5'b10101, 1'b0, LW'(2)};
    pv[2] = '{5'b00110, 1'b1, LW'(3)};
    pv[3] = '{5'b00111, 1'b0, LW'(4)};
    pv[4] = '{5'b00000, 1'b0, LW'(5)};
    for (int i = 0; i < 16; i++) burst_exp[i] = 5'(8'h10 + i);
    burst_exp[16] = 5'h07;
    for (int i = 0; i < 15; i++) bp_exp[i] = 5'(9 + i);
    bp_exp[15] = 5'h1D;

    bus.clear_from_pnl      = 1'b0;
    bus.tape_wr_valid       = 1'b0;
    bus.tape_wr_data        = '0;
    bus.punch_rd_ready      = 1'b0;
    bus.output_rdy_from_io  = 1'b0;
    bus.output_data_from_io = '0;

    // Reset state
    step(3);
    check("rst_in_rdy",   bus.input_rdy_to_io, 0);
    check("rst_in_data",  bus.input_data_to_io, 0);
    check("rst_out_ack",  bus.output_ack_to_io, 0);
    check("rst_pn_valid", bus.punch_rd_valid, 0);
    check("rst_pn_data",  bus.punch_rd_data, 0);
    check("rst_endp",     bus.punch_end_pulse, 0);
    check("rst_rd_lvl",   bus.reader_level, 0);
    check("rst_pn_lvl",   bus.punch_level, 0);
    check("rst_wr_ready", bus.tape_wr_ready, 0);
    resetn = 1'b1;
    step();
    check("post_rst_wr_ready", bus.tape_wr_ready, 1);

    // Reader single code
    auto_ack = 1'b1;
    host_write(5'b10011);
    check("single_lvl_e0", bus.reader_level, 1);
    check("single_rdy_e0", bus.input_rdy_to_io, 0);
    step();
    check("single_rdy_e1",  bus.input_rdy_to_io, 1);
    check("single_data_e1", bus.input_data_to_io, 5'b10011);
    check("single_lvl_e1",  bus.reader_level, 0);
    step(12);
    check("single_count", rd_got.size(), 1);
    if (rd_got.size() > 0) check("single_code", rd_got[0], 5'b10011);
    check("single_rdy_end", bus.input_rdy_to_io, 0);

    // Reader burst: fill with I/O unit stalled, then drain with ack
    auto_ack = 1'b0;
    rd_got.delete(); rise_cyc.delete(); fall_cyc.delete();
    for (int i = 0; i < 17; i++) host_write(burst_exp[i]);
    check("burst_lvl_full",  bus.reader_level, 16);
    check("burst_ready_low", bus.tape_wr_ready, 0);
    check("burst_head",      bus.input_data_to_io, 5'h10);
    auto_ack = 1'b1;
    for (t = 0; t < 400 && rd_got.size() < 17; t++) step();
    check("burst_count", rd_got.size(), 17);
    for (int i = 0; i < 17 && i < rd_got.size(); i++)
      check($sformatf("burst_code%0d", i), rd_got[i], burst_exp[i]);
    for (int i = 1; i < rise_cyc.size() && i <= fall_cyc.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(rise_cyc[i] >= fall_cyc[i-1] + GAP + 2), 1);
    step(12);
    check("burst_lvl_end", bus.reader_level, 0);
    auto_ack = 1'b0;

    // Punch vector table
    for (int i = 0; i < 5; i++) begin
      punch_send(pv[i].code, e0, e1);
      check($sformatf("pv%0d_endp", i),      e0, pv[i].endp);
      check($sformatf("pv%0d_endp_next", i), e1, 0);
      check($sformatf("pv%0d_lvl", i),       bus.punch_level, pv[i].lvl);
      check($sformatf("pv%0d_valid", i),     bus.punch_rd_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      drain_one(d);
      check($sformatf("pv%0d_drain", i), d, pv[i].code);
    end
    check("pv_lvl_empty",   bus.punch_level, 0);
    check("pv_valid_empty", bus.punch_rd_valid, 0);

    // Punch back-pressure
    for (int i = 0; i < 16; i++) punch_send(5'(8 + i), e0, e1);
    check("bp_lvl_full", bus.punch_level, 16);
    bus.output_data_from_io = 5'h1D;
    bus.output_rdy_from_io  = 1'b1;
    step(3);
    check("bp_ack_held", bus.output_ack_to_io, 0);
    check("bp_head", bus.punch_rd_data, 5'h08);
    bus.punch_rd_ready = 1'b1;
    step();
    bus.punch_rd_ready = 1'b0;
    check("bp_ack_pop_edge", bus.output_ack_to_io, 0);
    check("bp_lvl_pop",      bus.punch_level, 15);
    step();
    check("bp_ack_rise",  bus.output_ack_to_io, 1);
    check("bp_lvl_refill", bus.punch_level, 16);
    bus.output_rdy_from_io = 1'b0;
    step();
    check("bp_ack_fall", bus.output_ack_to_io, 0);
    for (int i = 0; i < 16; i++) begin
      drain_one(d);
      check($sformatf("bp_drain%0d", i), d, bp_exp[i]);
    end

    // Clear mid-handshake
    punch_send(5'h03, e0, e1);
    for (int i = 0; i < 6; i++) host_write(i == 0 ? 5'h15 : 5'(i));
    check("clr_pre_rdy",  bus.input_rdy_to_io, 1);
    check("clr_pre_data", bus.input_data_to_io, 5'h15);
    check("clr_pre_lvl",  bus.reader_level, 5);
    check("clr_pre_pn",   bus.punch_level, 1);
    bus.clear_from_pnl = 1'b1;
    step();
    bus.clear_from_pnl = 1'b0;
    check("clr_rd_lvl",   bus.reader_level, 0);
    check("clr_pn_lvl",   bus.punch_level, 0);
    check("clr_pn_valid", bus.punch_rd_valid, 0);
    check("clr_rdy_kept", bus.input_rdy_to_io, 1);
    check("clr_data_kept", bus.input_data_to_io, 5'h15);
    man_ack = 1'b1;
    step();
    check("clr_rdy_drop", bus.input_rdy_to_io, 0);
    man_ack = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.input_rdy_to_io) nrdy++;
    end
    check("clr_no_more_rdy", nrdy, 0);
    check("clr_data_hold", bus.input_data_to_io, 5'h15);

    // Reset mid-handshake
    bus.output_data_from_io = 5'h11;
    bus.output_rdy_from_io  = 1'b1;
    host_write(5'h0B);
    host_write(5'h0C);
    check("mr_pre_rdy", bus.input_rdy_to_io, 1);
    check("mr_pre_ack", bus.output_ack_to_io, 1);
    man_ack = 1'b1;
    resetn  = 1'b0;
    step();
    check("mr_in_rdy",   bus.input_rdy_to_io, 0);
    check("mr_in_data",  bus.input_data_to_io, 0);
    check("mr_out_ack",  bus.output_ack_to_io, 0);
    check("mr_pn_valid", bus.punch_rd_valid, 0);
    check("mr_pn_data",  bus.punch_rd_data, 0);
    check("mr_endp",     bus.punch_end_pulse, 0);
    check("mr_rd_lvl",   bus.reader_level, 0);
    check("mr_pn_lvl",   bus.punch_level, 0);
    check("mr_wr_ready", bus.tape_wr_ready, 0);
    man_ack = 1'b0;
    bus.output_rdy_from_io = 1'b0;
    resetn = 1'b1;
    step();
    check("mr_wr_ready_after", bus.tape_wr_ready, 1);

    // Randomized traffic against queue model
    auto_ack = 1'b1;
    rd_got.delete(); rise_cyc.delete(); fall_cyc.delete();
    for (int c = 0; c < 1500; c++) begin
      bus.tape_wr_valid = (c < 1200) && ($urandom_range(0, 2) == 0);
      bus.tape_wr_data  = 5'($urandom);
      if (bus.tape_wr_valid && bus.tape_wr_ready) exp_rd.push_back(bus.tape_wr_data);
      if (bus.output_rdy_from_io && bus.output_ack_to_io) begin
        exp_pn.push_back(bus.output_data_from_io);
        bus.output_rdy_from_io = 1'b0;
      end else if (!bus.output_rdy_from_io && !bus.output_ack_to_io &&
                   c < 1200 && $urandom_range(0, 3) == 0) begin
        bus.output_data_from_io = 5'($urandom);
        bus.output_rdy_from_io  = 1'b1;
      end
      check("rnd_pn_lvl", bus.punch_level, 32'(exp_pn.size() - got_pn.size()));
      bus.punch_rd_ready = (c >= 1200) || ($urandom_range(0, 2) == 0);
      if (bus.punch_rd_ready && bus.punch_rd_valid) got_pn.push_back(bus.punch_rd_data);
      step();
    end
    bus.tape_wr_valid  = 1'b0;
    bus.punch_rd_ready = 1'b0;
    check("rnd_rd_count", rd_got.size(), exp_rd.size());
    for (int i = 0; i < rd_got.size() && i < exp_rd.size(); i++)
      check($sformatf("rnd_rd%0d", i), rd_got[i], exp_rd[i]);
    check("rnd_pn_count", got_pn.size(), exp_pn.size());
    for (int i = 0; i < got_pn.size() && i < exp_pn.size(); i++)
      check($sformatf("rnd_pn%0d", i), got_pn[i], exp_pn[i]);
    check("rnd_rd_lvl_end", bus.reader_level, 0);
    check("rnd_pn_lvl_end", bus.punch_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/io_tape_dev.md
# io_tape_dev

Device-side endpoint of the 5-bit I/O handshake driven by the electronic I/O unit. It models the tape reader and tape punch. The reader presents buffered input codes with the rdy/ack four-phase handshake. The punch accepts output codes with the mirror handshake and buffers them for a host-side drain port. The block sits between the I/O unit and the host bridge or testbench that loads reader tape and collects punched output.

## Interface
- `DEPTH`, default 16: entries per FIFO; power of 2, at least 2.
- `GAP_CYCLES`, default 4: minimum idle cycles between the reader finishing one handshake and raising `rdy` again (models tape speed); 0 allowed.
- `clk` in 1: system clock.
- `resetn` in 1: one clock; reset is synchronous and active-low.
- `clear_from_pnl` in 1: pulse; empties both FIFOs.
- `tape_wr_valid` in 1: host offers a reader code.
- `tape_wr_ready` out 1: reader FIFO can accept.
- `tape_wr_data` in 5: reader code.
- `punch_rd_valid` out 1: punch FIFO non-empty.
- `punch_rd_ready` in 1: host takes the head entry.
- `punch_rd_data` out 5: punch FIFO head.
- `punch_end_pulse` out 1: pulse; a finish code (5'b00110) was just accepted by the punch.
- `reader_level` out clog2(DEPTH)+1: reader FIFO occupancy.
- `punch_level` out clog2(DEPTH)+1: punch FIFO occupancy.
- `input_rdy_to_io` out 1: handshake; reader data valid.
- `input_ack_from_io` in 1: handshake.
- `input_data_to_io` out 5: reader data.
- `output_rdy_from_io` in 1: handshake; punch data valid.
- `output_ack_to_io` out 1: handshake.
- `output_data_from_io` in 5: punch data.

## Operation
- Reader FIFO
  - Host write when `tape_wr_valid && tape_wr_ready`.
  - `tape_wr_ready = !full && resetn`; no write-through when full.
- Reader FSM: R_IDLE, R_RDY, R_ACKLOW, R_GAP. State is registered; `input_rdy_to_io` = (state == R_RDY).
  - R_IDLE: if the reader FIFO is non-empty, pop the head into `data_r` and go to R_RDY.
  - R_RDY: hold `data_r`. When `input_ack_from_io` is high, go to R_ACKLOW.
  - R_ACKLOW: wait for `!input_ack_from_io`. Then go to R_GAP with the counter set to GAP_CYCLES, or go straight to R_IDLE if GAP_CYCLES == 0.
  - R_GAP: decrement the counter. When it reaches 1, go to R_IDLE.
  - `input_data_to_io = data_r` at all times. `data_r` changes only on a pop.
- Punch FSM: P_IDLE, P_ACK. `output_ack_to_io` = (state == P_ACK).
  - P_IDLE: if `output_rdy_from_io` is high and the punch FIFO is not full, push `output_data_from_io` and go to P_ACK. If the FIFO is full, withhold ack (back-pressure).
  - P_ACK: when `!output_rdy_from_io`, go to P_IDLE.
  - Data is captured only on the cycle of the P_IDLE→P_ACK transition. Exactly one push per handshake.
- `punch_end_pulse`: registered, high one cycle after any push whose data == 5'b00110.
- Punch drain: pop when `punch_rd_valid && punch_rd_ready`. Simultaneous push and pop is allowed; the level is unchanged.
- `clear_from_pnl`:
  - Sets both FIFO levels and pointers to 0. It wins over a same-cycle host write, pop or punch push.
  - It does not abort handshakes in flight: `data_r` and the FSM states continue normally.
  - A push coinciding with clear is discarded, but the handshake still completes.

## Timing
- Reset values: `input_rdy_to_io`=0, `input_data_to_io`=0, `output_ack_to_io`=0, `punch_rd_valid`=0, `punch_rd_data`=0, `punch_end_pulse`=0, levels=0, `tape_wr_ready`=0 during reset and 1 after.
- Reset mid-handshake: FSMs return to their idle states and rdy/ack drop at the next edge. Reset is only applied together with system reset.
- Reader, write accepted at edge E0 into an empty FIFO:
  - E1: pop; `input_rdy_to_io` high after E1.
  - The first edge sampling ack high: rdy low.
  - The first edge sampling ack low: enter R_GAP.
  - The next rdy rises no earlier than GAP_CYCLES+1 edges after that.
- Punch:
  - `output_ack_to_io` rises one cycle after `output_rdy_from_io` is sampled high with the FIFO not full.
  - Ack falls one cycle after rdy is sampled low.
  - `punch_rd_valid` rises the cycle after the push edge.
- FIFO read data is available from registered storage. Full means level == DEPTH. Pointers wrap modulo DEPTH.

## Test plan
- Reader single code: GAP_CYCLES=4; write 5'b10011; auto-acking I/O model (ack 1 cycle after rdy, drops 1 cycle after rdy falls) -> rdy high the cycle after the write; data=5'b10011; exactly one handshake; reader_level returns to 0.
- Reader burst with gap: write 17 codes 5'h10..5'h1F then 5'h07 with DEPTH=16 -> `tape_wr_ready` low at level 16; codes delivered in order; consecutive rdy rises at least 4 cycles apart after ack falls.
- Punch stream: I/O model sends 5'b11110, 5'b10101, 5'b00110 -> FIFO holds the three codes in order; `punch_end_pulse` is high exactly once, after the third push.
- Punch back-pressure: fill the punch FIFO to 16 with `punch_rd_ready`=0; present a 17th code -> ack stays 0. Pop one -> ack rises the next cycle, and the 17th code is stored.
- Clear mid-handshake: reader in R_RDY with data 5'h15 and 5 codes queued; pulse `clear_from_pnl` -> reader_level 0; the handshake for 5'h15 completes; no further rdy.
- Reset mid-handshake: deassert resetn while rdy=1 and ack=1 -> all outputs 0 and levels 0 after the edge; `tape_wr_ready` is 1 the cycle after reset is released.
